mm_arbiter: RTL
===============

MM_ARBITER -- requirements
Module: mm_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 16, address width. DATA_W, default 16, data width. MAX_LOCK, default 8, maximum beats per locked burst.
REQ-002 Ports SHALL be:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- m_req[1:0]  in  2  per-master request, one transaction per cycle.
- m_lock[1:0]  in  2  per-master hold-bus request.
- m_we[1:0]  in  2  per-master write (1) or read (0).
- m0_addr / m1_addr  in  ADDR_W  master addresses.
- m0_wdata / m1_wdata  in  DATA_W  master write data.
- m_gnt[1:0]  out  2  one-hot grant; the transaction is accepted this cycle.
- m_rvalid[1:0]  out  2  read data valid for that master.
- m_rdata  out  DATA_W  read data shared by both masters; it is qualified by m_rvalid.
- addr  out  ADDR_W  slave address.
- wdata  out  DATA_W  slave write data.
- mm_we  out  1  slave write strobe.
- mm_re  out  1  slave read strobe.
- rdata  in  DATA_W  slave read data, valid one cycle after mm_re.
- Master 0 is the CPU data port. Master 1 is the DMA/debug port.

Function
REQ-003 Grant SHALL be combinational from m_req, the FSM state and the priority pointer; at most one m_gnt bit SHALL be high.
REQ-004 When m_gnt[i] is high, the slave outputs SHALL be driven in the same cycle:
- addr and wdata from master i.
- mm_we = m_we[i].
- mm_re = ~m_we[i].
REQ-005 When no master is granted, addr and wdata SHALL be 0, and mm_we and mm_re SHALL be 0.
REQ-006 Read latency SHALL be exactly 1 cycle. Read granted in cycle N → m_rvalid[i]=1 in cycle N+1, with m_rdata=rdata; the issuing master SHALL be held in a registered rd_owner.
REQ-007 Writes SHALL produce no m_rvalid.
REQ-008 Back-to-back transactions SHALL be sustained at 1 per cycle, including a read followed by a read from the other master.
REQ-009 FSM states SHALL be IDLE, LOCK0 and LOCK1.
REQ-010 IDLE behaviour:
- Arbitrate per REQ-015.
- If the winner i has m_lock[i]=1 → go to LOCKi with lock_cnt=1.
- Otherwise stay in IDLE.
REQ-011 LOCKi behaviour:
- Only master i may be granted.
- Each granted beat SHALL increment lock_cnt.
- The other master SHALL see m_gnt=0 even when requesting.
REQ-012 LOCKi → IDLE when m_lock[i]=0 at any cycle, or after the beat on which lock_cnt reaches MAX_LOCK. The pointer SHALL then favour the other master.
REQ-013 In LOCKi with m_req[i]=0 and m_lock[i]=1: no grant, and lock_cnt SHALL hold.
REQ-014 lock_cnt SHALL be $clog2(MAX_LOCK+1) bits wide and SHALL never wrap.

Configuration
REQ-015 With ARB_ROUND_ROBIN_EN defined:
- Simultaneous IDLE requests SHALL go to the master not granted last (1-bit pointer, reset to favour master 0).
- The pointer SHALL update on every IDLE grant and on forced lock release.
Without ARB_ROUND_ROBIN_EN:
- Fixed priority, master 0 wins.
- No pointer register.
- Forced release SHALL still return to IDLE, but master 0 wins again if it is requesting.

Reset
REQ-016 rst SHALL act on the next clock edge. It SHALL set:
- State to IDLE.
- lock_cnt to 0.
- Pointer to master 0.
- rd_owner valid to 0.
REQ-017 During and after reset, outputs SHALL be 0 until new requests are granted: m_gnt=0, m_rvalid=0, m_rdata=0, mm_we=0, mm_re=0, addr=0, wdata=0.
REQ-018 rst mid-burst or with a read in flight SHALL discard the pending m_rvalid and SHALL NOT generate any slave strobe in the reset cycle.

Structure
REQ-019 A shared package mm_pkg SHALL hold:
- The arb_state_t enum (IDLE, LOCK0, LOCK1).
- The MM_ADDR_W and MM_DATA_W constants.
- The MST_CPU=0 and MST_DMA=1 localparams.
REQ-020 One sub-module, mm_arb_prio, SHALL hold the 2-way grant logic (pointer or fixed priority). The FSM, counter and read-return register SHALL stay in mm_arbiter.

Verification
REQ-021 Single read: M0 reads 0x0010 with rdata=0xAAAA → m_gnt[0] and mm_re in cycle N; m_rvalid[0]=1 and m_rdata=0xAAAA in N+1.
REQ-022 Simultaneous contention: both masters write every cycle, no lock, RR enabled → grants alternate 0,1,0,1. With the macro off → master 0 is granted every cycle.
REQ-023 Lock limit: M1 holds lock and req for 12 cycles with MAX_LOCK=8 while M0 requests → M1 gets 8 grants, M0 is granted in cycle 9, and M1 re-arbitrates afterwards.
REQ-024 Lock idle: M0 holds lock with req low for 3 cycles while M1 requests → no grants. M0 drops lock → M1 is granted the next cycle.
REQ-025 Interleaved reads: M0 reads 0x0100 in N, M1 reads 0x0200 in N+1 → m_rvalid[0] in N+1 with rdata(0x0100), and m_rvalid[1] in N+2 with rdata(0x0200).
REQ-026 Reset during a read: rst asserted in the cycle after a granted read → m_rvalid stays 0 and the state is IDLE afterwards.

Source files
------------

// File: rtl/mm_pkg.sv
// Shared types and constants for the two-master memory-mapped arbiter.
// Round-robin arbitration is selected by defining ARB_ROUND_ROBIN_EN.
package mm_pkg;

  localparam int MM_ADDR_W = 16;
  localparam int MM_DATA_W = 16;

  localparam int MST_CPU = 0;
  localparam int MST_DMA = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_t;

  // Turns a master index into its one-hot grant/valid pattern.
  function automatic logic [1:0] mst_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mm_arb_prio.sv
// Two-way grant selection used while the arbiter is idle.
// ARB_ROUND_ROBIN_EN: ties go to the master named by ptr; otherwise the CPU always wins.
module mm_arb_prio
  import mm_pkg::*;
(
`ifdef ARB_ROUND_ROBIN_EN
  input  logic       ptr,
`endif
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    if (req[MST_CPU] && req[MST_DMA]) begin
`ifdef ARB_ROUND_ROBIN_EN
      gnt = mst_onehot(ptr);
`else
      gnt = mst_onehot(1'b0);
`endif
    end
  end

endmodule

// File: rtl/mm_arbiter.sv
// Two-master memory-mapped bus arbiter with locked bursts and 1-cycle read return.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking; default is fixed CPU priority.
module mm_arbiter
  import mm_pkg::*;
#(
  parameter int ADDR_W   = MM_ADDR_W,
  parameter int DATA_W   = MM_DATA_W,
  parameter int MAX_LOCK = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        m_req,
  input  logic [1:0]        m_lock,
  input  logic [1:0]        m_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic [1:0]        m_gnt,
  output logic [1:0]        m_rvalid,
  output logic [DATA_W-1:0] m_rdata,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata,
  output logic              mm_we,
  output logic              mm_re,
  input  logic [DATA_W-1:0] rdata
);

  localparam int CNT_W = $clog2(MAX_LOCK + 1);

  arb_state_t       state, state_nxt;
  logic [CNT_W-1:0] lock_cnt, lock_cnt_nxt;
  logic [1:0]       prio_gnt, gnt;
  logic             busy, sel, lock_own, last_beat;
  logic             rd_valid, rd_owner;
`ifdef ARB_ROUND_ROBIN_EN
  logic             ptr, ptr_nxt;
`endif

  mm_arb_prio u_prio (
`ifdef ARB_ROUND_ROBIN_EN
    .ptr (ptr),
`endif
    .req (m_req),
    .gnt (prio_gnt)
  );

  assign lock_own  = (state == LOCK1);
  assign last_beat = (lock_cnt >= CNT_W'(MAX_LOCK - 1));

  // Grants are suppressed in the reset cycle so no slave strobe escapes.
  always_comb begin
    gnt = 2'b00;
    if (!rst) begin
      case (state)
        IDLE:    gnt = prio_gnt;
        LOCK0:   gnt[MST_CPU] = m_req[MST_CPU];
        LOCK1:   gnt[MST_DMA] = m_req[MST_DMA];
        default: gnt = 2'b00;
      endcase
    end
  end

  assign busy  = |gnt;
  assign sel   = gnt[MST_DMA];
  assign m_gnt = gnt;

  assign addr  = busy ? (sel ? m1_addr  : m0_addr)  : '0;
  assign wdata = busy ? (sel ? m1_wdata : m0_wdata) : '0;
  assign mm_we = busy &  m_we[sel];
  assign mm_re = busy & ~m_we[sel];

  // The IDLE beat that starts a lock counts as the first beat of the burst.
  always_comb begin
    state_nxt    = state;
    lock_cnt_nxt = lock_cnt;
`ifdef ARB_ROUND_ROBIN_EN
    ptr_nxt      = ptr;
`endif
    case (state)
      IDLE: begin
        if (busy) begin
`ifdef ARB_ROUND_ROBIN_EN
          ptr_nxt = ~sel;
`endif
          if (m_lock[sel] && (MAX_LOCK > 1)) begin
            state_nxt    = sel ? LOCK1 : LOCK0;
            lock_cnt_nxt = CNT_W'(1);
          end
        end
      end
      LOCK0, LOCK1: begin
        if (!m_lock[lock_own] || (busy && last_beat)) begin
          state_nxt    = IDLE;
          lock_cnt_nxt = '0;
`ifdef ARB_ROUND_ROBIN_EN
          ptr_nxt      = ~lock_own;
`endif
        end else if (busy) begin
          lock_cnt_nxt = lock_cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt    = IDLE;
        lock_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      lock_cnt <= '0;
      rd_valid <= 1'b0;
      rd_owner <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      ptr      <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
      lock_cnt <= lock_cnt_nxt;
      rd_valid <= mm_re;
      if (mm_re) begin
        rd_owner <= sel;
      end
`ifdef ARB_ROUND_ROBIN_EN
      ptr      <= ptr_nxt;
`endif
    end
  end

  // A read still in flight when reset arrives is dropped immediately.
  assign m_rvalid = (rd_valid && !rst) ? mst_onehot(rd_owner) : 2'b00;
  assign m_rdata  = (rd_valid && !rst) ? rdata : '0;

endmodule
